exec_stage_p: RTL
=================

Name: exec_stage_p

Overview:
- Parametrised Decode→Execute pipeline stage for the ARM pipelined core.
- Holds D-stage controls and operands in E-stage registers, with enable-based stall (no clock gating), flush/bubble insertion and a valid bit.
- Contains the ALU, the NZCV flags register and ARM condition evaluation.
- Gates PCSrc/RegWrite/MemWrite by the condition result before they pass to the Memory stage.

Parameters:
DATA_W, 32, datapath width (operands, ALU result, write data)
RADDR_W, 4, destination register index width
FLAGS_INIT, 4'b0000, NZCV value loaded at reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
stall  input  1  hold E registers; flags not updated
flush  input  1  load a bubble into E next edge
validD  input  1  D-stage slot holds a real instruction
PCSrcD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD  input  1 each  decoded controls
FlagWriteD  input  2  [1]=write N,Z; [0]=write C,V
ALUControlD  input  4  ALU op
CondD  input  4  ARM condition field
RdD  input  RADDR_W  destination register
SrcAD, ShiftSourceD, ExtImmD  input  DATA_W each  operand A, register operand B / store data, extended immediate
PCSrcE, RegWriteE, MemtoRegE, MemWriteE  output  1 each  condition-gated controls to M
validE  output  1  E slot valid
CondExE  output  1  condition passed
RdE  output  RADDR_W  destination register
ALUResultE, WriteDataE  output  DATA_W each  ALU result, store data (=ShiftSourceE)
FlagsE  output  4  current NZCV register

Behaviour:
Reset (reset=0, asynchronous):
- All E registers clear to 0; Flags = FLAGS_INIT.
- All outputs therefore 0 except FlagsE.

Each rising edge, in priority order:
- flush=1: validE, PCSrc, RegWrite, MemWrite and FlagWrite registers clear to 0; data registers don't-care/hold. Flush beats stall.
- else stall=1: all E registers hold.
- else: all D inputs captured.

ALU (combinational on E registers):
- B = ALUSrcE ? ExtImmE : ShiftSourceE.
- Ops: 0000 ADD, 0001 SUB (A−B), 0010 AND, 0011 ORR, 0100 EOR, 0101 MOV (B). Others: result 0.
- N = result[DATA_W−1]; Z = (result==0).
- C: carry-out for ADD; NOT-borrow for SUB (A≥B unsigned → 1).
- V: signed overflow for ADD/SUB; C=V=0 for logic ops.

Condition evaluation (combinational, on FlagsE):
- 0000 EQ Z, 0001 NE !Z, 0010 CS C, 0011 CC !C, 0100 MI N, 0101 PL !N, 0110 VS V, 0111 VC !V.
- 1000 HI C&!Z, 1001 LS !C|Z, 1010 GE N==V, 1011 LT N!=V, 1100 GT !Z&(N==V), 1101 LE Z|(N!=V).
- 1110 AL and 1111 → 1.

Output gating:
- PCSrcE, RegWriteE, MemWriteE = stored bit & CondExE & validE.
- MemtoRegE and RdE pass through ungated.

Flags update, at the edge on which the E instruction leaves E (stall=0):
- Enabled when validE & CondExE.
- FlagWriteE[1] loads N,Z; FlagWriteE[0] loads C,V.
- Fresh ALU flags feed only the next instruction (one-cycle flag latency, no bypass).
- flush does not block the update of the instruction currently leaving E.
- With stall=1, no update, so a held instruction writes flags exactly once.

Reset mid-operation:
- Immediate clear of all state, including Flags.
- First instruction after reset release sees FLAGS_INIT.

Widths: arithmetic modulo 2^DATA_W; internal carry uses a DATA_W+1 adder.

Test Plan:
- Reset: reset=0 with arbitrary inputs toggling → all outputs 0, FlagsE=FLAGS_INIT; release, then one edge with validD=1, RegWriteD=1, CondD=1110 → RegWriteE=1.
- SUB setting flags: SrcAD=5, ShiftSourceD=5, ALUSrcD=0, ALUControlD=0001, FlagWriteD=11, CondD=1110 → ALUResultE=0. Next edge FlagsE=0110 (Z=1, C=1). Following EQ instruction RegWriteD=1 → RegWriteE=1; NE instruction → RegWriteE=0, CondExE=0.
- Overflow (DATA_W=32): ADD 0x7FFFFFFF+1 with FlagWrite=11 → ALUResultE=0x80000000, then FlagsE=1001.
- Stall: stall=1 for 3 cycles while D inputs change → E outputs constant, FlagsE updated once only when stall drops.
- Flush bubble: flush=1 with valid MemWriteD=1 → next cycle validE=0, MemWriteE=0, PCSrcE=0. flush=1 and stall=1 together → bubble inserted.
- Conditional failure blocks flags: CMP with CondD=0000 while Z=0 → FlagsE unchanged; ALU-immediate path ALUSrcD=1, ExtImmD=0xFF, MOV → ALUResultE=0xFF, WriteDataE=ShiftSourceD.

Source files
------------

// File: rtl/exec_stage_p_if.sv
// exec_stage_p_if -- bundle between the decode side and the execute stage.
//   master : decode/hazard side. Drives the D-stage controls, operands,
//            stall and flush. Receives the E-stage outputs.
//   slave  : the execute stage. Receives the D inputs and drives the E outputs.
// Widths follow DATA_W (datapath) and RADDR_W (register index).
interface exec_stage_p_if #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 4
);
   // hazard control
   logic               stall;
   logic               flush;
   // decode stage
   logic               validD;
   logic               PCSrcD;
   logic               RegWriteD;
   logic               MemtoRegD;
   logic               MemWriteD;
   logic               ALUSrcD;
   logic [1:0]         FlagWriteD;
   logic [3:0]         ALUControlD;
   logic [3:0]         CondD;
   logic [RADDR_W-1:0] RdD;
   logic [DATA_W-1:0]  SrcAD;
   logic [DATA_W-1:0]  ShiftSourceD;
   logic [DATA_W-1:0]  ExtImmD;
   // execute stage
   logic               PCSrcE;
   logic               RegWriteE;
   logic               MemtoRegE;
   logic               MemWriteE;
   logic               validE;
   logic               CondExE;
   logic [RADDR_W-1:0] RdE;
   logic [DATA_W-1:0]  ALUResultE;
   logic [DATA_W-1:0]  WriteDataE;
   logic [3:0]         FlagsE;

   modport master (
      output stall, flush, validD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD,
             ALUSrcD, FlagWriteD, ALUControlD, CondD, RdD, SrcAD,
             ShiftSourceD, ExtImmD,
      input  PCSrcE, RegWriteE, MemtoRegE, MemWriteE, validE, CondExE, RdE,
             ALUResultE, WriteDataE, FlagsE
   );

   modport slave (
      input  stall, flush, validD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD,
             ALUSrcD, FlagWriteD, ALUControlD, CondD, RdD, SrcAD,
             ShiftSourceD, ExtImmD,
      output PCSrcE, RegWriteE, MemtoRegE, MemWriteE, validE, CondExE, RdE,
             ALUResultE, WriteDataE, FlagsE
   );
endinterface

// File: rtl/exec_stage_p.sv
// exec_stage_p -- Decode->Execute pipeline stage of the ARM pipelined core.
// Holds the D-stage controls and operands in E registers. Stall is an enable,
// and flush loads a bubble. The stage also contains the ALU, the NZCV register
// and ARM condition evaluation. PCSrc, RegWrite and MemWrite are gated by the
// condition result and by the valid bit before they go to the Memory stage.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : exec_stage_p_if.slave (D inputs, stall/flush, E outputs)
module exec_stage_p #(
   parameter int         DATA_W     = 32,
   parameter int         RADDR_W    = 4,
   parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
   input  logic          clk,
   input  logic          reset,
   exec_stage_p_if.slave bus
);

   logic               valid_reg, pcsrc_reg, regwrite_reg, memtoreg_reg;
   logic               memwrite_reg, alusrc_reg;
   logic [1:0]         flagwrite_reg;
   logic [3:0]         aluctl_reg, cond_reg;
   logic [RADDR_W-1:0] rd_reg;
   logic [DATA_W-1:0]  srca_reg, shsrc_reg, extimm_reg;
   logic [3:0]         flags_reg;                 // {N,Z,C,V}

   logic [DATA_W-1:0]  alu_b, alu_res;
   logic [DATA_W:0]    sum, diff;
   logic               alu_n, alu_z, alu_c, alu_v;
   logic               condex;

   // E pipeline registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_reg     <= 1'b0;
         pcsrc_reg     <= 1'b0;
         regwrite_reg  <= 1'b0;
         memtoreg_reg  <= 1'b0;
         memwrite_reg  <= 1'b0;
         alusrc_reg    <= 1'b0;
         flagwrite_reg <= 2'b00;
         aluctl_reg    <= 4'h0;
         cond_reg      <= 4'h0;
         rd_reg        <= '0;
         srca_reg      <= '0;
         shsrc_reg     <= '0;
         extimm_reg    <= '0;
      end else if (bus.flush) begin
         // Bubble: only the side-effecting bits are cleared. The data
         // registers keep their old values because they are don't-care.
         valid_reg     <= 1'b0;
         pcsrc_reg     <= 1'b0;
         regwrite_reg  <= 1'b0;
         memwrite_reg  <= 1'b0;
         flagwrite_reg <= 2'b00;
      end else if (!bus.stall) begin
         valid_reg     <= bus.validD;
         pcsrc_reg     <= bus.PCSrcD;
         regwrite_reg  <= bus.RegWriteD;
         memtoreg_reg  <= bus.MemtoRegD;
         memwrite_reg  <= bus.MemWriteD;
         alusrc_reg    <= bus.ALUSrcD;
         flagwrite_reg <= bus.FlagWriteD;
         aluctl_reg    <= bus.ALUControlD;
         cond_reg      <= bus.CondD;
         rd_reg        <= bus.RdD;
         srca_reg      <= bus.SrcAD;
         shsrc_reg     <= bus.ShiftSourceD;
         extimm_reg    <= bus.ExtImmD;
      end
   end

   // Flags are written when the instruction leaves E, and stall=0 marks that
   // edge. A flush on the same edge still lets the leaving instruction commit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_reg <= FLAGS_INIT;
      end else if (!bus.stall && valid_reg && condex) begin
         if (flagwrite_reg[1]) flags_reg[3:2] <= {alu_n, alu_z};
         if (flagwrite_reg[0]) flags_reg[1:0] <= {alu_c, alu_v};
      end
   end

   // ALU
   assign alu_b = alusrc_reg ? extimm_reg : shsrc_reg;
   assign sum   = {1'b0, srca_reg} + {1'b0, alu_b};
   // A + ~B + 1: the carry out is the ARM NOT-borrow
   assign diff  = {1'b0, srca_reg} + {1'b0, ~alu_b} + {{DATA_W{1'b0}}, 1'b1};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (aluctl_reg)
         4'b0000: begin
            alu_res = sum[DATA_W-1:0];
            alu_c   = sum[DATA_W];
            alu_v   = (srca_reg[DATA_W-1] == alu_b[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != srca_reg[DATA_W-1]);
         end
         4'b0001: begin
            alu_res = diff[DATA_W-1:0];
            alu_c   = diff[DATA_W];
            alu_v   = (srca_reg[DATA_W-1] != alu_b[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != srca_reg[DATA_W-1]);
         end
         4'b0010: alu_res = srca_reg & alu_b;
         4'b0011: alu_res = srca_reg | alu_b;
         4'b0100: alu_res = srca_reg ^ alu_b;
         4'b0101: alu_res = alu_b;
         default: alu_res = '0;
      endcase
   end

   assign alu_n = alu_res[DATA_W-1];
   assign alu_z = (alu_res == '0);

   // Condition check against the committed flags (no bypass of fresh ALU flags)
   always_comb begin
      condex = 1'b1;
      case (cond_reg)
         4'b0000: condex = flags_reg[2];
         4'b0001: condex = !flags_reg[2];
         4'b0010: condex = flags_reg[1];
         4'b0011: condex = !flags_reg[1];
         4'b0100: condex = flags_reg[3];
         4'b0101: condex = !flags_reg[3];
         4'b0110: condex = flags_reg[0];
         4'b0111: condex = !flags_reg[0];
         4'b1000: condex = flags_reg[1] && !flags_reg[2];
         4'b1001: condex = !flags_reg[1] || flags_reg[2];
         4'b1010: condex = (flags_reg[3] == flags_reg[0]);
         4'b1011: condex = (flags_reg[3] != flags_reg[0]);
         4'b1100: condex = !flags_reg[2] && (flags_reg[3] == flags_reg[0]);
         4'b1101: condex = flags_reg[2] || (flags_reg[3] != flags_reg[0]);
         default: condex = 1'b1;
      endcase
   end

   // Outputs to the Memory stage
   assign bus.PCSrcE     = pcsrc_reg    & condex & valid_reg;
   assign bus.RegWriteE  = regwrite_reg & condex & valid_reg;
   assign bus.MemWriteE  = memwrite_reg & condex & valid_reg;
   assign bus.MemtoRegE  = memtoreg_reg;
   assign bus.validE     = valid_reg;
   assign bus.CondExE    = condex;
   assign bus.RdE        = rd_reg;
   assign bus.ALUResultE = alu_res;
   assign bus.WriteDataE = shsrc_reg;
   assign bus.FlagsE     = flags_reg;

endmodule
